top_system: RTL and testbench

TOP_SYSTEM -- requirements
Module: top_system

---
 rtl/top_system.sv | 267 ++++++++++++++++++++++++++
 tb/tb_top_system.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_system.sv
// -----------------------------------------------------------------------------
// top_system
// Streaming convolution engine. A layer starts with a one-cycle start pulse,
// loads one weight vector per output channel and kernel tap, then consumes one
// activation beat per tap and emits one accumulated result per
// (y, x, output channel). Results stream out in y, x, channel order.
//
// Ports
//   clk           : single clock, rising edge
//   arst_n_in     : asynchronous active-low reset
//   input0..3     : signed lanes; weights while loading, activations in compute
//   input4        : signed bias lane, used on the first tap of each result
//   valid         : qualifies input0..input4 for this cycle
//   start         : one-cycle pulse that begins a layer (honoured only in IDLE)
//   running       : high while a layer is in progress
//   out           : signed accumulated result
//   output_valid  : one-cycle strobe qualifying out and the coordinates
//   output_x/y/ch : coordinates of the result on out
// -----------------------------------------------------------------------------
module top_system #(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int ACCUMULATION_WIDTH = 32,
   parameter int EXT_MEM_HEIGHT     = 1 << 20,
   parameter int EXT_MEM_WIDTH      = 32,
   parameter int FEATURE_MAP_WIDTH  = 64,
   parameter int FEATURE_MAP_HEIGHT = 64,
   parameter int INPUT_NB_CHANNELS  = 4,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int KERNEL_SIZE        = 3
) (
   input  logic                                    clk,
   input  logic                                    arst_n_in,
   input  logic [IO_DATA_WIDTH-1:0]                input0,
   input  logic [IO_DATA_WIDTH-1:0]                input1,
   input  logic [IO_DATA_WIDTH-1:0]                input2,
   input  logic [IO_DATA_WIDTH-1:0]                input3,
   input  logic [IO_DATA_WIDTH-1:0]                input4,
   input  logic                                    valid,
   input  logic                                    start,
   output logic                                    running,
   output logic [ACCUMULATION_WIDTH-1:0]           out,
   output logic                                    output_valid,
   output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
   output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
   output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch
);

   localparam int K2     = KERNEL_SIZE * KERNEL_SIZE;
   localparam int NW     = OUTPUT_NB_CHANNELS * K2;
   localparam int WAW    = (NW > 1) ? $clog2(NW) : 1;
   localparam int TW     = (K2 > 1) ? $clog2(K2) : 1;
   localparam int XW     = $clog2(FEATURE_MAP_WIDTH);
   localparam int YW     = $clog2(FEATURE_MAP_HEIGHT);
   localparam int CW     = $clog2(OUTPUT_NB_CHANNELS);
   localparam int PW     = 2 * IO_DATA_WIDTH;
   localparam int LANE_W = INPUT_NB_CHANNELS * IO_DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_W  = 2'd1,
      COMPUTE = 2'd2
   } state_t;

   state_t                          state_r;
   state_t                          state_nxt_s;

   logic [WAW-1:0]                  w_cnt_r;
   logic [WAW-1:0]                  rd_addr_s;
   logic [TW-1:0]                   tap_r;
   logic [CW-1:0]                   co_r;
   logic [XW-1:0]                   x_r;
   logic [YW-1:0]                   y_r;

   logic signed [ACCUMULATION_WIDTH-1:0] acc_r;
   logic signed [ACCUMULATION_WIDTH-1:0] mac_s;
   logic signed [ACCUMULATION_WIDTH-1:0] acc_nxt_s;
   logic signed [PW-1:0]            prod_s;

   // one packed vector of all input-channel weights per (co, tap)
   logic [LANE_W-1:0]               weight_r [NW];
   logic [LANE_W-1:0]               w_in_s;
   logic [LANE_W-1:0]               w_row_s;
   logic [IO_DATA_WIDTH-1:0]        act_s [4];

   logic                            w_last_s;
   logic                            tap_last_s;
   logic                            co_last_s;
   logic                            x_last_s;
   logic                            y_last_s;
   logic                            layer_last_s;

   logic                            running_r;
   logic                            output_valid_r;
   logic signed [ACCUMULATION_WIDTH-1:0] out_r;
   logic [XW-1:0]                   output_x_r;
   logic [YW-1:0]                   output_y_r;
   logic [CW-1:0]                   output_ch_r;

   assign act_s[0] = input0;
   assign act_s[1] = input1;
   assign act_s[2] = input2;
   assign act_s[3] = input3;

   assign w_last_s     = (w_cnt_r == WAW'(NW - 1));
   assign tap_last_s   = (tap_r == TW'(K2 - 1));
   assign co_last_s    = (co_r == CW'(OUTPUT_NB_CHANNELS - 1));
   assign x_last_s     = (x_r == XW'(FEATURE_MAP_WIDTH - 1));
   assign y_last_s     = (y_r == YW'(FEATURE_MAP_HEIGHT - 1));
   assign layer_last_s = tap_last_s && co_last_s && x_last_s && y_last_s;

   // weights are laid out co-major, tap-minor, matching the load order
   assign rd_addr_s = WAW'(int'(co_r) * K2 + int'(tap_r));
   assign w_row_s   = weight_r[rd_addr_s];

   assign running      = running_r;
   assign output_valid = output_valid_r;
   assign out          = out_r;
   assign output_x     = output_x_r;
   assign output_y     = output_y_r;
   assign output_ch    = output_ch_r;

   // pack the incoming lanes into one weight-memory word
   always_comb begin
      w_in_s = '0;
      for (int ci = 0; ci < INPUT_NB_CHANNELS; ci++) begin
         w_in_s[ci*IO_DATA_WIDTH +: IO_DATA_WIDTH] = act_s[ci];
      end
   end

   // dot product of this beat and the next accumulator value (wraps modulo 2^ACC)
   always_comb begin
      mac_s  = '0;
      prod_s = '0;
      for (int ci = 0; ci < INPUT_NB_CHANNELS; ci++) begin
         prod_s = PW'($signed(act_s[ci])) *
                  PW'($signed(w_row_s[ci*IO_DATA_WIDTH +: IO_DATA_WIDTH]));
         mac_s  = mac_s + ACCUMULATION_WIDTH'(prod_s);
      end
      if (tap_r == '0) begin
         acc_nxt_s = ACCUMULATION_WIDTH'($signed(input4)) + mac_s;
      end else begin
         acc_nxt_s = acc_r + mac_s;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = LOAD_W;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD_W: begin
            if (valid && w_last_s) begin
               state_nxt_s = COMPUTE;
            end else begin
               state_nxt_s = LOAD_W;
            end
         end
         COMPUTE: begin
            if (valid && layer_last_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = COMPUTE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // weight storage; contents survive reset and are overwritten on every load
   always_ff @(posedge clk) begin
      if ((state_r == LOAD_W) && valid) begin
         weight_r[w_cnt_r] <= w_in_s;
      end
   end

   // counters, accumulator and registered outputs
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         running_r      <= 1'b0;
         output_valid_r <= 1'b0;
         out_r          <= '0;
         output_x_r     <= '0;
         output_y_r     <= '0;
         output_ch_r    <= '0;
         w_cnt_r        <= '0;
         tap_r          <= '0;
         co_r           <= '0;
         x_r            <= '0;
         y_r            <= '0;
         acc_r          <= '0;
      end else begin
         // running follows the state being entered, so it falls with the last strobe
         running_r      <= (state_nxt_s != IDLE);
         output_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  w_cnt_r <= '0;
                  tap_r   <= '0;
                  co_r    <= '0;
                  x_r     <= '0;
                  y_r     <= '0;
                  acc_r   <= '0;
               end
            end
            LOAD_W: begin
               if (valid) begin
                  if (w_last_s) begin
                     w_cnt_r <= '0;
                  end else begin
                     w_cnt_r <= w_cnt_r + WAW'(1);
                  end
               end
            end
            COMPUTE: begin
               if (valid) begin
                  acc_r <= acc_nxt_s;
                  if (tap_last_s) begin
                     tap_r          <= '0;
                     output_valid_r <= 1'b1;
                     out_r          <= acc_nxt_s;
                     output_x_r     <= x_r;
                     output_y_r     <= y_r;
                     output_ch_r    <= co_r;
                     if (co_last_s) begin
                        co_r <= '0;
                        if (x_last_s) begin
                           x_r <= '0;
                           if (y_last_s) begin
                              y_r <= '0;
                           end else begin
                              y_r <= y_r + YW'(1);
                           end
                        end else begin
                           x_r <= x_r + XW'(1);
                        end
                     end else begin
                        co_r <= co_r + CW'(1);
                     end
                  end else begin
                     tap_r <= tap_r + TW'(1);
                  end
               end
            end
            default: begin
               w_cnt_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_top_system.sv
// -----------------------------------------------------------------------------
// tb_top_system
// Directed bench for top_system on a reduced map (4 x 2, 2 output channels,
// 3x3 kernel) so full layers stay short. Each scenario task drives its own
// stimulus and compares against hand-computed or bench-modelled values.
// -----------------------------------------------------------------------------
module tb_top_system;

   localparam int IOW  = 16;
   localparam int ACCW = 32;
   localparam int FMW  = 4;
   localparam int FMH  = 2;
   localparam int OC   = 2;
   localparam int K    = 3;
   localparam int K2   = K * K;

   logic              clk = 1'b0;
   logic              arst_n_in;
   logic [IOW-1:0]    input0, input1, input2, input3, input4;
   logic              valid;
   logic              start;
   logic              running;
   logic [ACCW-1:0]   out;
   logic              output_valid;
   logic [1:0]        output_x;
   logic [0:0]        output_y;
   logic [0:0]        output_ch;

   int n_tests = 0;
   int n_fail  = 0;
   int dut_pulses = 0;
   logic signed [31:0] last_exp;

   top_system #(
      .IO_DATA_WIDTH(IOW), .ACCUMULATION_WIDTH(ACCW),
      .EXT_MEM_HEIGHT(1 << 20), .EXT_MEM_WIDTH(32),
      .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
      .INPUT_NB_CHANNELS(4), .OUTPUT_NB_CHANNELS(OC), .KERNEL_SIZE(K)
   ) dut (
      .clk(clk), .arst_n_in(arst_n_in),
      .input0(input0), .input1(input1), .input2(input2), .input3(input3),
      .input4(input4), .valid(valid), .start(start),
      .running(running), .out(out), .output_valid(output_valid),
      .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
   );

   always #5 clk = ~clk;

   // strobe counter; a strobe longer than one cycle is seen more than once
   always @(negedge clk) begin
      if (output_valid === 1'b1) dut_pulses = dut_pulses + 1;
   end

   function automatic int wval(int mode, int co, int tap, int ci);
      case (mode)
         0: return 1;
         1: return (ci == 0) ? -2 : 0;
         2: return 32767;
         default: return co * 3 + tap - ci * 2 + 1;
      endcase
   endfunction

   function automatic int aval(int mode, int y, int x, int co, int tap, int ci);
      case (mode)
         0: return 1;
         1: return (ci == 0) ? 32767 : 7;
         2: return 32767;
         default: return y * 7 + x * 5 + tap * 3 + ci + co * 11 - 9;
      endcase
   endfunction

   function automatic int bval(int mode, int y, int x, int co);
      case (mode)
         1: return 5;
         3: return y * 100 + x * 10 + co - 50;
         default: return 0;
      endcase
   endfunction

   function automatic logic signed [31:0] exp_out(int mode, int y, int x, int co);
      int acc;
      case (mode)
         0: return 32'sd36;
         1: return -32'sd589801;
         2: return -32'sd2359260;
         default: begin
            acc = bval(mode, y, x, co);
            for (int t = 0; t < K2; t++)
               for (int c = 0; c < 4; c++)
                  acc = acc + aval(mode, y, x, co, t, c) * wval(mode, co, t, c);
            return 32'(acc);
         end
      endcase
   endfunction

   task automatic idle_cycle();
      valid  = 1'b0;
      input0 = 16'($urandom);
      input1 = 16'($urandom);
      input2 = 16'($urandom);
      input3 = 16'($urandom);
      input4 = 16'($urandom);
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load_weights(input int mode, input bit gaps);
      for (int co = 0; co < OC; co++) begin
         for (int t = 0; t < K2; t++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
            input0 = 16'(wval(mode, co, t, 0));
            input1 = 16'(wval(mode, co, t, 1));
            input2 = 16'(wval(mode, co, t, 2));
            input3 = 16'(wval(mode, co, t, 3));
            input4 = 16'h7fff;
            valid  = 1'b1;
            @(posedge clk); #1;
            valid  = 1'b0;
         end
      end
   endtask

   task automatic run_layer(input int mode, input bit gaps, input bit start_mid, input string name);
      bit last;
      dut_pulses = 0;
      pulse_start();
      n_tests++;
      if (running !== 1'b1) begin
         n_fail++;
         $display("FAIL %s running_after_start: got %b expected 1", name, running);
      end
      load_weights(mode, gaps);
      for (int y = 0; y < FMH; y++) begin
         for (int x = 0; x < FMW; x++) begin
            for (int co = 0; co < OC; co++) begin
               for (int t = 0; t < K2; t++) begin
                  if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
                  input0 = 16'(aval(mode, y, x, co, t, 0));
                  input1 = 16'(aval(mode, y, x, co, t, 1));
                  input2 = 16'(aval(mode, y, x, co, t, 2));
                  input3 = 16'(aval(mode, y, x, co, t, 3));
                  input4 = 16'(bval(mode, y, x, co));
                  if (start_mid && (y == 0) && (x == 1) && (t == 4)) start = 1'b1;
                  valid = 1'b1;
                  @(posedge clk); #1;
                  valid = 1'b0;
                  start = 1'b0;
                  n_tests++;
                  if (t == K2 - 1) begin
                     last_exp = exp_out(mode, y, x, co);
                     last = (y == FMH - 1) && (x == FMW - 1) && (co == OC - 1);
                     if ((output_valid !== 1'b1) || ($signed(out) !== last_exp) ||
                         (output_x !== 2'(x)) || (output_y !== 1'(y)) ||
                         (output_ch !== 1'(co)) || (running !== !last)) begin
                        n_fail++;
                        $display("FAIL %s result(y%0d,x%0d,c%0d): got v=%b out=%0d x=%0d y=%0d ch=%0d run=%b expected v=1 out=%0d run=%b",
                                 name, y, x, co, output_valid, $signed(out), output_x,
                                 output_y, output_ch, running, last_exp, !last);
                     end
                  end else begin
                     if (output_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s stray_valid(y%0d,x%0d,c%0d,t%0d): got %b expected 0",
                                 name, y, x, co, t, output_valid);
                     end
                  end
               end
            end
         end
      end
      idle_cycle();
      idle_cycle();
      n_tests++;
      if ((running !== 1'b0) || (output_valid !== 1'b0) || ($signed(out) !== last_exp) ||
          (dut_pulses != FMW * FMH * OC)) begin
         n_fail++;
         $display("FAIL %s end_of_layer: got run=%b v=%b out=%0d pulses=%0d expected run=0 v=0 out=%0d pulses=%0d",
                  name, running, output_valid, $signed(out), dut_pulses, last_exp, FMW * FMH * OC);
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if ((running !== 1'b0) || (output_valid !== 1'b0) || (out !== 32'd0) ||
          (output_x !== 2'd0) || (output_y !== 1'd0) || (output_ch !== 1'd0)) begin
         n_fail++;
         $display("FAIL reset_state: got run=%b v=%b out=%0d x=%0d y=%0d ch=%0d expected all 0",
                  running, output_valid, out, output_x, output_y, output_ch);
      end
      arst_n_in = 1'b1;
      idle_cycle();
      n_tests++;
      if ((running !== 1'b0) || (output_valid !== 1'b0)) begin
         n_fail++;
         $display("FAIL after_release: got run=%b v=%b expected 0 0", running, output_valid);
      end
   endtask

   task automatic test_idle_valid();
      for (int i = 0; i < 5; i++) begin
         input0 = 16'($urandom);
         input1 = 16'($urandom);
         input4 = 16'($urandom);
         valid  = 1'b1;
         @(posedge clk); #1;
         valid  = 1'b0;
         n_tests++;
         if ((running !== 1'b0) || (output_valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL idle_valid[%0d]: got run=%b v=%b expected 0 0", i, running, output_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      pulse_start();
      load_weights(3, 1'b0);
      for (int i = 0; i < 20; i++) begin
         input0 = 16'(i);
         input1 = 16'(i + 3);
         input2 = 16'(i * 2);
         input3 = 16'(5);
         input4 = 16'(i + 100);
         valid  = 1'b1;
         @(posedge clk); #1;
         valid  = 1'b0;
      end
      #2;
      arst_n_in = 1'b0;
      #1;
      n_tests++;
      if ((running !== 1'b0) || (output_valid !== 1'b0) || (out !== 32'd0) ||
          (output_x !== 2'd0) || (output_ch !== 1'd0)) begin
         n_fail++;
         $display("FAIL reset_mid_async: got run=%b v=%b out=%0d x=%0d ch=%0d expected all 0",
                  running, output_valid, out, output_x, output_ch);
      end
      @(posedge clk); #1;
      arst_n_in = 1'b1;
      idle_cycle();
      n_tests++;
      if ((running !== 1'b0) || (output_valid !== 1'b0)) begin
         n_fail++;
         $display("FAIL reset_mid_release: got run=%b v=%b expected 0 0", running, output_valid);
      end
      run_layer(3, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_all_ones();
      run_layer(0, 1'b0, 1'b0, "all_ones");
   endtask

   task automatic test_neg_weight();
      run_layer(1, 1'b0, 1'b0, "neg_weight");
   endtask

   task automatic test_overflow();
      run_layer(2, 1'b0, 1'b0, "overflow");
   endtask

   task automatic test_pattern();
      run_layer(3, 1'b0, 1'b0, "pattern");
   endtask

   task automatic test_gaps();
      run_layer(3, 1'b1, 1'b0, "gaps");
   endtask

   task automatic test_start_ignored();
      run_layer(3, 1'b0, 1'b1, "start_mid");
   endtask

   initial begin
      arst_n_in = 1'b0;
      valid  = 1'b0;
      start  = 1'b0;
      input0 = 16'd0;
      input1 = 16'd0;
      input2 = 16'd0;
      input3 = 16'd0;
      input4 = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_idle_valid();
      test_all_ones();
      test_neg_weight();
      test_overflow();
      test_pattern();
      test_gaps();
      test_start_ignored();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
